game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//   Round sequencer for the whack-a-mole game. Drives the 2-bit game state
//   consumed by the game datapath: 00 STATUS, 01 PLAY, 10 PAUSE, 11 FINISH.
//   Owns the round countdown, the one-second tick used for mole timing, and
//   the best-score register. Sits between the debounced buttons and the
//   game core. Single clock domain: clk_500hz.
// PARAMETERS
//   TICKS_PER_SEC  500  clk_500hz cycles per game second (>=2)
//   ROUND_SECS     30   round length in seconds (1..99)
//   FINISH_SECS    5    seconds FINISH is held before auto-return to STATUS (>=1)
//   SCORE_W        8    width of score / best_score, unsigned
// PORTS
//   clk_500hz    in   1        system clock, rising edge
//   rst_n        in   1        asynchronous, active-low reset
//   btn_start    in   1        start/skip request, one-cycle pulse, pre-debounced
//   btn_pause    in   1        pause/resume request, one-cycle pulse, pre-debounced
//   score        in   SCORE_W  current round score from game core
//   state        out  2        game state (encoding above)
//   time_left    out  7        seconds remaining in round
//   sec_tick     out  1        one-cycle pulse per elapsed second in PLAY
//   round_start  out  1        one-cycle pulse; game core clears score/moles
//   best_score   out  SCORE_W  highest final score since reset
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=00, time_left=ROUND_SECS, sec_tick=0,
//     round_start=0, best_score=0, prescaler=0, hold counter=0. Takes effect
//     immediately, including mid-round; no pulses are emitted on release.
//   - All outputs are registered. State changes occur on the edge that samples
//     the request: 1-cycle latency from a button pulse to the new state.
//   - STATUS: btn_start -> PLAY. Same edge: time_left=ROUND_SECS, prescaler=0,
//     round_start=1 for exactly that one cycle. btn_pause is ignored.
//   - PLAY: prescaler counts 0..TICKS_PER_SEC-1 and wraps. On a wrap edge:
//     sec_tick=1 for one cycle and time_left decrements. On the wrap edge
//     where time_left goes 1->0, state -> FINISH on the same edge.
//     btn_pause -> PAUSE (prescaler frozen, not cleared). btn_start ignored.
//   - PAUSE: prescaler and time_left frozen; sec_tick=0. btn_pause or
//     btn_start -> PLAY; counting resumes from the frozen prescaler value.
//   - FINISH: time_left stays 0; sec_tick=0. Hold counter runs for
//     FINISH_SECS*TICKS_PER_SEC cycles, then state -> STATUS.
//     btn_start -> STATUS immediately. btn_pause is ignored.
//   - Simultaneous events:
//       start+pause in STATUS  -> start wins.
//       start+pause in PLAY    -> pause wins.
//       pause on expiry edge   -> expiry wins (FINISH).
//   - time_left saturates at 0 and never wraps. Prescaler width is
//     $clog2(TICKS_PER_SEC). Hold counter width is
//     $clog2(FINISH_SECS*TICKS_PER_SEC).
// CONFIGURATION
//   GAME_CTRL_HIGH_SCORE_EN defined:
//     - On the edge entering FINISH, if score > best_score (unsigned),
//       best_score <= score.
//     - best_score is otherwise held; it is cleared only by rst_n.
//   GAME_CTRL_HIGH_SCORE_EN undefined:
//     - No best-score register is built; best_score is constant 0.
// TESTING (TICKS_PER_SEC=10, ROUND_SECS=3, FINISH_SECS=2 for sim)
//   1. rst_n 0->1, pulse btn_start -> next edge: state=01, round_start=1 for
//      one cycle, time_left=3.
//   2. PLAY for 10 cycles -> sec_tick high one cycle on the 10th edge,
//      time_left=2; no other sec_tick pulses.
//   3. Pause after 4 PLAY cycles, wait 50 cycles -> state=10, time_left
//      unchanged, sec_tick=0; resume -> next sec_tick exactly 6 cycles later.
//   4. Run uninterrupted 30 cycles from start -> state=11 and time_left=0 on
//      the same edge; 20 cycles later -> state=00.
//   5. HIGH_SCORE_EN: score=42 at FINISH -> best_score=42; next round
//      score=17 -> best_score stays 42. Macro undefined -> best_score=0.
//   6. rst_n=0 mid-PLAY with time_left=1 -> state=00, time_left=3
//      immediately (asynchronous), best_score=0.

Source files
------------

// File: rtl/game_ctrl_if.sv
// Handshake bundle between the button/score side and the game_ctrl round sequencer.
interface game_ctrl_if #(
  parameter int unsigned SCORE_W = 8
);
  logic               btn_start;
  logic               btn_pause;
  logic [SCORE_W-1:0] score;
  logic [1:0]         state;
  logic [6:0]         time_left;
  logic               sec_tick;
  logic               round_start;
  logic [SCORE_W-1:0] best_score;

  modport master (
    output btn_start, btn_pause, score,
    input  state, time_left, sec_tick, round_start, best_score
  );

  modport slave (
    input  btn_start, btn_pause, score,
    output state, time_left, sec_tick, round_start, best_score
  );
endinterface

// File: rtl/game_ctrl.sv
// Whack-a-mole round sequencer: game state, round countdown, second tick, best score.
// Optional best-score register enabled by defining GAME_CTRL_HIGH_SCORE_EN.
module game_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 500,
  parameter int unsigned ROUND_SECS    = 30,
  parameter int unsigned FINISH_SECS   = 5,
  parameter int unsigned SCORE_W       = 8
) (
  input  logic       clk_500hz,
  input  logic       rst_n,
  game_ctrl_if.slave bus
);

  localparam int unsigned PW        = $clog2(TICKS_PER_SEC);
  localparam int unsigned HOLD_CYC  = FINISH_SECS * TICKS_PER_SEC;
  localparam int unsigned HW        = $clog2(HOLD_CYC);

  typedef enum logic [1:0] {
    ST_STATUS = 2'b00,
    ST_PLAY   = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_FINISH = 2'b11
  } state_t;

  state_t        state_q;
  logic [PW-1:0] psc_q;
  logic [HW-1:0] hold_q;
  logic [6:0]    time_q;
  logic          tick_q;
  logic          rs_q;
  logic          wrap_c;
  logic          expire_c;

  // Expiry is the wrap edge that takes the countdown from 1 to 0.
  assign wrap_c   = (state_q == ST_PLAY) && (psc_q == PW'(TICKS_PER_SEC - 1));
  assign expire_c = wrap_c && (time_q == 7'd1);

  always_ff @(posedge clk_500hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STATUS;
      psc_q   <= '0;
      hold_q  <= '0;
      time_q  <= 7'(ROUND_SECS);
      tick_q  <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      rs_q   <= 1'b0;
      case (state_q)
        ST_STATUS: begin
          if (bus.btn_start) begin
            state_q <= ST_PLAY;
            time_q  <= 7'(ROUND_SECS);
            psc_q   <= '0;
            rs_q    <= 1'b1;
          end
        end
        ST_PLAY: begin
          // The pause edge still counts; the prescaler freezes from PAUSE onward.
          if (wrap_c) begin
            psc_q  <= '0;
            tick_q <= 1'b1;
            if (time_q != 7'd0) time_q <= time_q - 7'd1;
          end else begin
            psc_q <= psc_q + PW'(1);
          end
          if (expire_c) begin
            state_q <= ST_FINISH;
            hold_q  <= '0;
          end else if (bus.btn_pause) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (bus.btn_pause || bus.btn_start) state_q <= ST_PLAY;
        end
        ST_FINISH: begin
          if (bus.btn_start || (hold_q == HW'(HOLD_CYC - 1))) begin
            state_q <= ST_STATUS;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.time_left   = time_q;
  assign bus.sec_tick    = tick_q;
  assign bus.round_start = rs_q;

`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [SCORE_W-1:0] best_q;

  // Final score is the one presented on the edge that enters FINISH.
  always_ff @(posedge clk_500hz or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= '0;
    end else if (expire_c && (bus.score > best_q)) begin
      best_q <= bus.score;
    end
  end

  assign bus.best_score = best_q;
`else
  logic unused_score;
  assign unused_score   = ^bus.score;
  assign bus.best_score = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed vector table, hand sequences, and
// randomized buttons/score compared against a cycle-level behavioural model.
module tb_game_ctrl;

  localparam int unsigned TPS     = 10;
  localparam int unsigned ROUND   = 3;
  localparam int unsigned FIN     = 2;
  localparam int unsigned SCORE_W = 8;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic clk_500hz = 1'b0;
  logic rst_n     = 1'b0;

  game_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  game_ctrl #(
    .TICKS_PER_SEC(TPS),
    .ROUND_SECS   (ROUND),
    .FINISH_SECS  (FIN),
    .SCORE_W      (SCORE_W)
  ) dut (
    .clk_500hz(clk_500hz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_500hz = ~clk_500hz;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: mode 0 STATUS, 1 PLAY, 2 PAUSE, 3 FINISH.
  int m_mode, m_time, m_sub, m_fin_elapsed, m_best;
  bit m_tick, m_rs;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_time = ROUND; m_sub = 0; m_fin_elapsed = 0; m_best = 0;
    m_tick = 0; m_rs = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input int sc);
    m_tick = 0;
    m_rs   = 0;
    case (m_mode)
      0: if (s) begin m_mode = 1; m_time = ROUND; m_sub = 0; m_rs = 1; end
      1: begin
        m_sub = m_sub + 1;
        if (m_sub == TPS) begin
          m_sub  = 0;
          m_tick = 1;
          if (m_time > 0) m_time = m_time - 1;
        end
        if (m_tick && m_time == 0) begin
          m_mode = 3;
          m_fin_elapsed = 0;
          if (HS && sc > m_best) m_best = sc;
        end else if (p) begin
          m_mode = 2;
        end
      end
      2: if (s || p) m_mode = 1;
      default: begin
        m_fin_elapsed = m_fin_elapsed + 1;
        if (s || m_fin_elapsed == FIN * TPS) m_mode = 0;
      end
    endcase
  endtask

  task automatic check_model(string tag);
    chk({tag, ".state"},       int'(bus.state),       m_mode);
    chk({tag, ".time_left"},   int'(bus.time_left),   m_time);
    chk({tag, ".sec_tick"},    int'(bus.sec_tick),    int'(m_tick));
    chk({tag, ".round_start"}, int'(bus.round_start), int'(m_rs));
    chk({tag, ".best_score"},  int'(bus.best_score),  m_best);
  endtask

  // One clock: drive inputs, let the edge sample them, step the model, compare.
  task automatic cycle(input bit s, input bit p, input int sc, input string tag);
    bus.btn_start = s;
    bus.btn_pause = p;
    bus.score     = SCORE_W'(sc);
    @(posedge clk_500hz);
    #1;
    model_step(s, p, sc);
    check_model(tag);
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
  endtask

  typedef struct {
    int wait_n;
    bit start;
    bit pause;
    int score;
    int st;
    int tl;
    bit tick;
    bit rs;
    int best;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int b42;
    b42 = HS ? 42 : 0;
    vecs[0]  = '{0,  1'b1, 1'b0, 5,  1, 3, 1'b0, 1'b1, 0};   // start
    vecs[1]  = '{8,  1'b0, 1'b0, 5,  1, 3, 1'b0, 1'b0, 0};   // 9th edge, no tick
    vecs[2]  = '{0,  1'b0, 1'b0, 5,  1, 2, 1'b1, 1'b0, 0};   // 10th edge tick
    vecs[3]  = '{0,  1'b0, 1'b0, 5,  1, 2, 1'b0, 1'b0, 0};
    vecs[4]  = '{2,  1'b0, 1'b1, 5,  2, 2, 1'b0, 1'b0, 0};   // pause, psc=4
    vecs[5]  = '{49, 1'b0, 1'b0, 5,  2, 2, 1'b0, 1'b0, 0};   // frozen
    vecs[6]  = '{0,  1'b0, 1'b1, 5,  1, 2, 1'b0, 1'b0, 0};   // resume
    vecs[7]  = '{4,  1'b0, 1'b0, 5,  1, 2, 1'b0, 1'b0, 0};   // 5 after resume
    vecs[8]  = '{0,  1'b0, 1'b0, 5,  1, 1, 1'b1, 1'b0, 0};   // 6 after resume
    vecs[9]  = '{8,  1'b1, 1'b1, 42, 2, 1, 1'b0, 1'b0, 0};   // pause wins in PLAY
    vecs[10] = '{0,  1'b1, 1'b0, 42, 1, 1, 1'b0, 1'b0, 0};   // start resumes
    vecs[11] = '{0,  1'b0, 1'b1, 42, 3, 0, 1'b1, 1'b0, b42}; // expiry beats pause
    vecs[12] = '{18, 1'b0, 1'b0, 9,  3, 0, 1'b0, 1'b0, b42};
    vecs[13] = '{0,  1'b0, 1'b0, 9,  0, 0, 1'b0, 1'b0, b42}; // auto-return
    vecs[14] = '{0,  1'b1, 1'b1, 17, 1, 3, 1'b0, 1'b1, b42}; // start wins in STATUS
    vecs[15] = '{29, 1'b0, 1'b0, 17, 3, 0, 1'b1, 1'b0, b42}; // lower score kept out
    vecs[16] = '{0,  1'b0, 1'b1, 17, 3, 0, 1'b0, 1'b0, b42}; // pause ignored
    vecs[17] = '{0,  1'b1, 1'b0, 17, 0, 0, 1'b0, 1'b0, b42}; // skip FINISH
    vecs[18] = '{0,  1'b0, 1'b1, 17, 0, 0, 1'b0, 1'b0, b42}; // pause ignored
    vecs[19] = '{0,  1'b1, 1'b0, 17, 1, 3, 1'b0, 1'b1, b42};
  end

  initial begin
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    bus.score     = '0;
    model_reset();
    #1;
    repeat (3) @(posedge clk_500hz);
    #1;
    chk("reset.state",     int'(bus.state),     0);
    chk("reset.time_left", int'(bus.time_left), int'(ROUND));
    chk("reset.best",      int'(bus.best_score), 0);
    @(negedge clk_500hz);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 0, "post_reset");
    chk("post_reset.no_pulse", int'(bus.round_start), 0);

    for (int i = 0; i < 20; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      for (int w = 0; w < vecs[i].wait_n; w++) cycle(1'b0, 1'b0, vecs[i].score, tag);
      cycle(vecs[i].start, vecs[i].pause, vecs[i].score, tag);
      chk({tag, ".tbl_state"}, int'(bus.state),       vecs[i].st);
      chk({tag, ".tbl_time"},  int'(bus.time_left),   vecs[i].tl);
      chk({tag, ".tbl_tick"},  int'(bus.sec_tick),    int'(vecs[i].tick));
      chk({tag, ".tbl_rs"},    int'(bus.round_start), int'(vecs[i].rs));
      chk({tag, ".tbl_best"},  int'(bus.best_score),  vecs[i].best);
    end

    // Asynchronous reset mid-PLAY with one second left.
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 17, "to_last_sec");
    chk("midplay.time_before", int'(bus.time_left), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.state",     int'(bus.state),      0);
    chk("async_rst.time_left", int'(bus.time_left),  int'(ROUND));
    chk("async_rst.best",      int'(bus.best_score), 0);
    chk("async_rst.tick",      int'(bus.sec_tick),   0);
    model_reset();
    #3 rst_n = 1'b1;

    for (int k = 0; k < 4000; k++) begin
      bit s, p;
      s = ($urandom_range(0, 24) == 0);
      p = ($urandom_range(0, 19) == 0);
      cycle(s, p, int'($urandom_range(0, 255)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
